id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register directly upstream of the RV32I ALU. Captures decoded operands and

---
 rtl/id_ex_operand_stage_if.sv | 51 +++++
 rtl/id_ex_operand_stage.sv | 121 ++++++++++++
 tb/tb_id_ex_operand_stage.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/id_ex_operand_stage_if.sv
// Bus between decode, the ID/EX operand stage and the ALU, plus the EX/MEM and MEM/WB forwarding taps.
interface id_ex_operand_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              flush;
  logic              id_valid;
  logic              id_ready;
  logic [XLEN-1:0]   id_pc;
  logic [REG_AW-1:0] id_rs1_addr;
  logic [REG_AW-1:0] id_rs2_addr;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic              id_op1_sel;
  logic              id_op2_sel;
  logic [3:0]        id_alu_op;
  logic [REG_AW-1:0] id_rd_addr;
  logic              id_reg_write;
  logic [REG_AW-1:0] exmem_rd;
  logic              exmem_we;
  logic [XLEN-1:0]   exmem_result;
  logic [REG_AW-1:0] memwb_rd;
  logic              memwb_we;
  logic [XLEN-1:0]   memwb_result;
  logic              ex_valid;
  logic              ex_ready;
  logic [XLEN-1:0]   ex_op1;
  logic [XLEN-1:0]   ex_op2;
  logic [XLEN-1:0]   ex_rs2_fwd;
  logic [3:0]        ex_alu_op;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_reg_write;
  logic              ex_illegal;

  modport master (
    output flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_op1_sel, id_op2_sel, id_alu_op, id_rd_addr, id_reg_write,
           exmem_rd, exmem_we, exmem_result, memwb_rd, memwb_we, memwb_result, ex_ready,
    input  id_ready, ex_valid, ex_op1, ex_op2, ex_rs2_fwd, ex_alu_op, ex_rd_addr,
           ex_reg_write, ex_illegal
  );

  modport slave (
    input  flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_op1_sel, id_op2_sel, id_alu_op, id_rd_addr, id_reg_write,
           exmem_rd, exmem_we, exmem_result, memwb_rd, memwb_we, memwb_result, ex_ready,
    output id_ready, ex_valid, ex_op1, ex_op2, ex_rs2_fwd, ex_alu_op, ex_rd_addr,
           ex_reg_write, ex_illegal
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX register feeding the RV32I ALU: single-entry valid/ready stage with EX/MEM + MEM/WB
// forwarding on the held source operands and MEM/WB refresh of held data during stalls.

// One source operand's bypass mux; EX/MEM wins over MEM/WB, x0 never matches.
module id_ex_fwd_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              en,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [XLEN-1:0]   rs_data,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_we,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_we,
  input  logic [XLEN-1:0]   memwb_result,
  output logic [XLEN-1:0]   fwd
);
  logic hit_exmem, hit_memwb;

  assign hit_exmem = en && exmem_we && (exmem_rd != '0) && (exmem_rd == rs_addr);
  assign hit_memwb = en && memwb_we && (memwb_rd != '0) && (memwb_rd == rs_addr);
  assign fwd = hit_exmem ? exmem_result :
               hit_memwb ? memwb_result : rs_data;
endmodule

module id_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  id_ex_operand_stage_if.slave bus
);
  localparam int NSRC = 2;

  typedef struct packed {
    logic [XLEN-1:0]                  pc;
    logic [XLEN-1:0]                  imm;
    logic [NSRC-1:0][REG_AW-1:0]      rs_addr;
    logic [NSRC-1:0][XLEN-1:0]        rs_data;
    logic                             op1_sel;
    logic                             op2_sel;
    logic [3:0]                       alu_op;
    logic [REG_AW-1:0]                rd_addr;
    logic                             reg_write;
    logic                             illegal;
  } held_t;

  held_t                       h, cap;
  logic                        vld;
  logic                        xfer;
  logic                        ill_in;
  logic [NSRC-1:0][XLEN-1:0]   fwd;

  assign bus.id_ready = !vld || bus.ex_ready;
  assign xfer         = bus.id_valid && bus.id_ready && !bus.flush;
  assign ill_in       = bus.id_alu_op > 4'd9;

  always_comb begin
    cap            = '0;
    cap.pc         = bus.id_pc;
    cap.imm        = bus.id_imm;
    cap.rs_addr[0] = bus.id_rs1_addr;
    cap.rs_addr[1] = bus.id_rs2_addr;
    cap.rs_data[0] = bus.id_rs1_data;
    cap.rs_data[1] = bus.id_rs2_data;
    cap.op1_sel    = bus.id_op1_sel;
    cap.op2_sel    = bus.id_op2_sel;
    cap.alu_op     = ill_in ? 4'd0 : bus.id_alu_op;
    cap.rd_addr    = bus.id_rd_addr;
    cap.reg_write  = bus.id_reg_write && !ill_in;
    cap.illegal    = ill_in;
  end

  // Refresh keeps a value that retires from MEM/WB while we stall from being lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= 1'b0;
      h   <= '0;
    end else begin
      if (bus.flush)        vld <= 1'b0;
      else if (xfer)        vld <= 1'b1;
      else if (bus.ex_ready) vld <= 1'b0;

      if (xfer) begin
        h <= cap;
      end else if (vld) begin
        for (int i = 0; i < NSRC; i++)
          if (bus.memwb_we && (bus.memwb_rd != '0) && (bus.memwb_rd == h.rs_addr[i]))
            h.rs_data[i] <= bus.memwb_result;
      end
    end
  end

  // Bypass only while valid so the outputs hold still when the stage is empty.
  for (genvar g = 0; g < NSRC; g++) begin : g_fwd
    id_ex_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd (
      .en          (vld),
      .rs_addr     (h.rs_addr[g]),
      .rs_data     (h.rs_data[g]),
      .exmem_rd    (bus.exmem_rd),
      .exmem_we    (bus.exmem_we),
      .exmem_result(bus.exmem_result),
      .memwb_rd    (bus.memwb_rd),
      .memwb_we    (bus.memwb_we),
      .memwb_result(bus.memwb_result),
      .fwd         (fwd[g])
    );
  end

  assign bus.ex_valid     = vld;
  assign bus.ex_op1       = h.op1_sel ? h.pc  : fwd[0];
  assign bus.ex_op2       = h.op2_sel ? h.imm : fwd[1];
  assign bus.ex_rs2_fwd   = fwd[1];
  assign bus.ex_alu_op    = h.alu_op;
  assign bus.ex_rd_addr   = h.rd_addr;
  assign bus.ex_reg_write = vld && h.reg_write;
  assign bus.ex_illegal   = vld && h.illegal;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, capture, forwarding, stall refresh, flush, streaming, illegal op.
module tb_id_ex_operand_stage;
  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  id_ex_operand_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

  id_ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                      input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                      input logic s1, input logic s2, input logic [3:0] op,
                      input logic [4:0] rd, input logic we);
    bus.id_valid     = 1'b1;
    bus.id_pc        = pc;
    bus.id_rs1_addr  = rs1;
    bus.id_rs1_data  = d1;
    bus.id_rs2_addr  = rs2;
    bus.id_rs2_data  = d2;
    bus.id_imm       = imm;
    bus.id_op1_sel   = s1;
    bus.id_op2_sel   = s2;
    bus.id_alu_op    = op;
    bus.id_rd_addr   = rd;
    bus.id_reg_write = we;
  endtask

  task automatic clr_fwd();
    bus.exmem_we = 1'b0; bus.exmem_rd = '0; bus.exmem_result = '0;
    bus.memwb_we = 1'b0; bus.memwb_rd = '0; bus.memwb_result = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.ex_ready = 1'b0;
    clr_fwd();
    send(32'h40, 5'd1, 32'h99, 5'd2, 32'h98, 32'h7, 1'b0, 1'b1, 4'd0, 5'd3, 1'b1);

    // Reset with id_valid high must not capture.
    step(); step();
    chk("rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_op1",   bus.ex_op1, 32'h0);
    chk("rst_op2",   bus.ex_op2, 32'h0);
    chk("rst_ready", 32'(bus.id_ready), 32'd1);
    rst_n = 1'b1;
    bus.id_valid = 1'b0;
    step();
    chk("idle_valid", 32'(bus.ex_valid), 32'd0);

    // Basic capture, held under stall.
    send(32'h100, 5'd5, 32'h10, 5'd6, 32'h20, 32'h4, 1'b0, 1'b1, 4'd0, 5'd1, 1'b1);
    step();
    bus.id_valid = 1'b0;
    chk("basic_valid", 32'(bus.ex_valid), 32'd1);
    chk("basic_op1",   bus.ex_op1, 32'h10);
    chk("basic_op2",   bus.ex_op2, 32'h4);
    chk("basic_aluop", 32'(bus.ex_alu_op), 32'd0);
    chk("basic_rs2f",  bus.ex_rs2_fwd, 32'h20);
    chk("basic_we",    32'(bus.ex_reg_write), 32'd1);
    chk("basic_rd",    32'(bus.ex_rd_addr), 32'd1);
    chk("full_ready",  32'(bus.id_ready), 32'd0);
    bus.ex_ready = 1'b1;
    step();
    chk("drain_valid", 32'(bus.ex_valid), 32'd0);
    chk("drain_we",    32'(bus.ex_reg_write), 32'd0);

    // Forwarding priority on a held rs1=3.
    bus.ex_ready = 1'b0;
    send(32'h104, 5'd3, 32'h11, 5'd8, 32'h22, 32'h0, 1'b0, 1'b0, 4'd1, 5'd4, 1'b1);
    step();
    bus.id_valid = 1'b0;
    bus.exmem_we = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'hAA;
    bus.memwb_we = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'hBB;
    #1 chk("fwd_exmem", bus.ex_op1, 32'hAA);
    bus.exmem_we = 1'b0;
    #1 chk("fwd_memwb", bus.ex_op1, 32'hBB);
    clr_fwd();
    #1 chk("fwd_none", bus.ex_op1, 32'h11);
    chk("fwd_op2", bus.ex_op2, 32'h22);

    // x0 is never forwarded or refreshed.
    bus.ex_ready = 1'b1;
    send(32'h108, 5'd0, 32'h33, 5'd9, 32'h44, 32'h0, 1'b0, 1'b0, 4'd2, 5'd5, 1'b1);
    bus.exmem_we = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'hAA;
    bus.memwb_we = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'hBB;
    step();
    bus.id_valid = 1'b0;
    bus.ex_ready = 1'b0;
    chk("x0_op1", bus.ex_op1, 32'h33);
    step();
    chk("x0_hold", bus.ex_op1, 32'h33);
    clr_fwd();

    // Stall refresh of held rs2=7 from MEM/WB.
    bus.ex_ready = 1'b1;
    send(32'h10C, 5'd10, 32'h1, 5'd7, 32'h01, 32'h8, 1'b0, 1'b1, 4'd3, 5'd6, 1'b1);
    step();
    bus.id_valid = 1'b0;
    bus.ex_ready = 1'b0;
    bus.memwb_we = 1'b1; bus.memwb_rd = 5'd7; bus.memwb_result = 32'h55;
    #1 chk("stall_fwd", bus.ex_rs2_fwd, 32'h55);
    step();
    clr_fwd();
    step(); step();
    chk("stall_valid", 32'(bus.ex_valid), 32'd1);
    chk("stall_rs2f",  bus.ex_rs2_fwd, 32'h55);
    chk("stall_op2",   bus.ex_op2, 32'h8);

    // Flush beats a pending capture.
    send(32'h110, 5'd11, 32'h66, 5'd12, 32'h67, 32'h77, 1'b0, 1'b1, 4'd4, 5'd7, 1'b1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.id_valid = 1'b0;
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_we",    32'(bus.ex_reg_write), 32'd0);
    chk("flush_nocap", bus.ex_op2, 32'h8);
    chk("flush_ready", 32'(bus.id_ready), 32'd1);

    // Back-to-back stream with ex_ready held high.
    bus.ex_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(32'h200 + 32'(4 * i), 5'd1, 32'h0, 5'd2, 32'h0, 32'(i), 1'b1, 1'b1, 4'(i), 5'd1, 1'b1);
      step();
      chk("b2b_valid", 32'(bus.ex_valid), 32'd1);
      chk("b2b_op1",   bus.ex_op1, 32'h200 + 32'(4 * i));
    end
    bus.id_valid = 1'b0;
    step();
    chk("b2b_drain", 32'(bus.ex_valid), 32'd0);

    // Highest legal code then an illegal one.
    send(32'h300, 5'd1, 32'h0, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0, 4'd9, 5'd8, 1'b1);
    step();
    chk("sltu_op",  32'(bus.ex_alu_op), 32'd9);
    chk("sltu_ill", 32'(bus.ex_illegal), 32'd0);
    send(32'h304, 5'd1, 32'h0, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0, 4'd12, 5'd8, 1'b1);
    step();
    bus.id_valid = 1'b0;
    bus.ex_ready = 1'b0;
    chk("ill_flag",  32'(bus.ex_illegal), 32'd1);
    chk("ill_aluop", 32'(bus.ex_alu_op), 32'd0);
    chk("ill_we",    32'(bus.ex_reg_write), 32'd0);
    chk("ill_valid", 32'(bus.ex_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
